// File: rtl/plasma_pkg.sv
// Shared constants and types for the plasma background phase generator.
package plasma_pkg;

    localparam int ACC_W   = 16;
    localparam int PHASE_W = 10;

    localparam logic [1:0] CFG_H = 2'd0;
    localparam logic [1:0] CFG_V = 2'd1;
    localparam logic [1:0] CFG_F = 2'd2;

    localparam logic [ACC_W-1:0] DEF_H_STEP = 16'h0100;
    localparam logic [ACC_W-1:0] DEF_V_STEP = 16'h0080;
    localparam logic [ACC_W-1:0] DEF_F_STEP = 16'h0040;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [ACC_W-1:0] h;
        logic [ACC_W-1:0] v;
        logic [ACC_W-1:0] f;
    } step_set_t;

    localparam step_set_t DEF_STEPS = '{h: DEF_H_STEP, v: DEF_V_STEP, f: DEF_F_STEP};

endpackage

// File: rtl/plasma_step_regs.sv
// Double-buffered step registers: config writes land in the pending set,
// which is copied to the active set only on frame_start so a frame never tears.
module plasma_step_regs
    import plasma_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [ACC_W-1:0] cfg_data,
    input  logic             frame_start,
    output logic [ACC_W-1:0] h_step_act,
    output logic [ACC_W-1:0] v_step_act,
    output logic [ACC_W-1:0] f_step_act
);

    step_set_t pend_q, pend_d;
    step_set_t act_q, act_d;

    always_comb begin
        pend_d = pend_q;
        if (cfg_we) begin
            case (cfg_sel)
                CFG_H:   pend_d.h = cfg_data;
                CFG_V:   pend_d.v = cfg_data;
                CFG_F:   pend_d.f = cfg_data;
                default: pend_d = pend_q;
            endcase
        end
    end

    // The copy takes the pending value from before any coincident write,
    // so data written on a frame_start applies one frame later.
    always_comb begin
        act_d = act_q;
        if (frame_start) begin
            act_d = pend_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= DEF_STEPS;
            act_q  <= DEF_STEPS;
        end else begin
            pend_q <= pend_d;
            act_q  <= act_d;
        end
    end

    assign h_step_act = act_q.h;
    assign v_step_act = act_q.v;
    assign f_step_act = act_q.f;

endmodule

// File: rtl/plasma_phase_gen.sv
// Plasma phase generator: frame/line/pixel modular accumulators producing one
// registered 10-bit cosine-lookup phase per active pixel.
module plasma_phase_gen
    import plasma_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_ce,
    input  logic               active_video,
    input  logic               line_start,
    input  logic               frame_start,
    input  logic               freeze,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_sel,
    input  logic [ACC_W-1:0]   cfg_data,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid
);

    logic [ACC_W-1:0] h_step_act;
    logic [ACC_W-1:0] v_step_act;
    logic [ACC_W-1:0] f_step_act;

    plasma_step_regs u_step_regs (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_data    (cfg_data),
        .frame_start (frame_start),
        .h_step_act  (h_step_act),
        .v_step_act  (v_step_act),
        .f_step_act  (f_step_act)
    );

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   f_acc_q, f_acc_d;
    logic [ACC_W-1:0]   v_acc_q, v_acc_d;
    logic [ACC_W-1:0]   h_acc_q, h_acc_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               phase_valid_q, phase_valid_d;
    logic [ACC_W-1:0]   frame_base;

    // Priority frame_start > line_start > pixel; a pixel on either pulse is dropped.
    always_comb begin
        state_d       = state_q;
        f_acc_d       = f_acc_q;
        v_acc_d       = v_acc_q;
        h_acc_d       = h_acc_q;
        phase_d       = phase_q;
        phase_valid_d = 1'b0;
        frame_base    = freeze ? f_acc_q : f_acc_q + f_step_act;

        if (frame_start) begin
            state_d = ST_RUN;
            f_acc_d = frame_base;
            h_acc_d = frame_base;
            v_acc_d = frame_base + v_step_act;
        end else if (state_q == ST_RUN) begin
            if (line_start) begin
                h_acc_d = v_acc_q;
                v_acc_d = v_acc_q + v_step_act;
            end else if (pix_ce && active_video) begin
                phase_d       = h_acc_q[ACC_W-1 -: PHASE_W];
                h_acc_d       = h_acc_q + h_step_act;
                phase_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            f_acc_q       <= '0;
            v_acc_q       <= '0;
            h_acc_q       <= '0;
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            f_acc_q       <= f_acc_d;
            v_acc_q       <= v_acc_d;
            h_acc_q       <= h_acc_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;

endmodule

// File: tb/tb_plasma_phase_gen.sv
// Directed bench for plasma_phase_gen with hand-computed phase values.
module tb_plasma_phase_gen;

    logic        clk;
    logic        reset;
    logic        pix_ce;
    logic        active_video;
    logic        line_start;
    logic        frame_start;
    logic        freeze;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_data;
    logic [9:0]  phase;
    logic        phase_valid;

    int total = 0;
    int bad   = 0;

    plasma_phase_gen dut (
        .clk          (clk),
        .reset        (reset),
        .pix_ce       (pix_ce),
        .active_video (active_video),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .freeze       (freeze),
        .cfg_we       (cfg_we),
        .cfg_sel      (cfg_sel),
        .cfg_data     (cfg_data),
        .phase        (phase),
        .phase_valid  (phase_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pixel(input string tag, input logic [9:0] exp);
        pix_ce = 1'b1;
        active_video = 1'b1;
        tick();
        pix_ce = 1'b0;
        active_video = 1'b0;
        chk({tag, "_valid"}, {15'd0, phase_valid}, 16'd1);
        chk({tag, "_phase"}, {6'd0, phase}, {6'd0, exp});
    endtask

    task automatic pixel_dropped(input string tag);
        pix_ce = 1'b1;
        active_video = 1'b1;
        tick();
        pix_ce = 1'b0;
        active_video = 1'b0;
        chk({tag, "_valid"}, {15'd0, phase_valid}, 16'd0);
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("frame_valid", {15'd0, phase_valid}, 16'd0);
    endtask

    task automatic line();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        chk("line_valid", {15'd0, phase_valid}, 16'd0);
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [15:0] data);
        cfg_we = 1'b1;
        cfg_sel = sel;
        cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pix_ce = 1'b0;
        active_video = 1'b0;
        line_start = 1'b0;
        frame_start = 1'b0;
        freeze = 1'b0;
        cfg_we = 1'b0;
        cfg_sel = 2'd0;
        cfg_data = 16'h0000;
        #3;
        chk("rst_phase", {6'd0, phase}, 16'd0);
        chk("rst_valid", {15'd0, phase_valid}, 16'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // IDLE: pixels and line_start ignored until the first frame_start
        for (int i = 0; i < 10; i++) pixel_dropped("idle_pix");
        chk("idle_phase", {6'd0, phase}, 16'd0);
        line_start = 1'b1;
        pixel_dropped("idle_pix_line");
        line_start = 1'b0;

        // First frame, default steps: f=0x40, h=0x40, v=0xC0
        frame();
        pixel("f1_p0", 10'd1);
        pixel("f1_p1", 10'd5);
        pixel("f1_p2", 10'd9);
        pixel("f1_p3", 10'd13);
        tick();
        chk("valid_drops", {15'd0, phase_valid}, 16'd0);
        chk("phase_holds", {6'd0, phase}, 16'd13);

        line();
        pixel("l1_p0", 10'd3);
        pixel("l1_p1", 10'd7);
        pixel("l1_p2", 10'd11);
        line();
        pixel("l2_p0", 10'd5);

        // pix_ce without active_video produces nothing
        pix_ce = 1'b1;
        tick();
        pix_ce = 1'b0;
        chk("inactive_valid", {15'd0, phase_valid}, 16'd0);

        // Mid-frame h_step write stays pending
        cfg_write(2'd0, 16'hFFC0);
        pixel("pend_p0", 10'd9);
        pixel("pend_p1", 10'd13);

        frame();
        pixel("f2_p0", 10'd2);
        pixel("f2_p1", 10'd1);
        pixel("f2_p2", 10'd0);
        pixel("f2_p3", 10'd1023);

        freeze = 1'b1;
        frame();
        pixel("frz1", 10'd2);
        frame();
        pixel("frz2", 10'd2);
        freeze = 1'b0;
        frame();
        pixel("unfrz", 10'd3);

        // Coincident pixels are dropped in RUN
        line_start = 1'b1;
        pixel_dropped("run_pix_line");
        line_start = 1'b0;
        frame_start = 1'b1;
        pixel_dropped("run_pix_frame");
        frame_start = 1'b0;

        // Reset mid-line
        reset = 1'b1;
        tick();
        reset = 1'b0;
        frame();
        pixel("r_p0", 10'd1);
        pixel("r_p1", 10'd5);
        pixel("r_p2", 10'd9);
        reset = 1'b1;
        #1;
        chk("midrst_phase", {6'd0, phase}, 16'd0);
        chk("midrst_valid", {15'd0, phase_valid}, 16'd0);
        tick();
        reset = 1'b0;
        pixel_dropped("postrst_p0");
        pixel_dropped("postrst_p1");
        chk("postrst_phase", {6'd0, phase}, 16'd0);
        frame();
        pixel("postrst_first", 10'd1);

        // frame_start with cfg_we: new f_step applies one frame later
        frame_start = 1'b1;
        cfg_we = 1'b1;
        cfg_sel = 2'd2;
        cfg_data = 16'h0080;
        tick();
        frame_start = 1'b0;
        cfg_we = 1'b0;
        pixel("fw_f0", 10'd2);
        frame();
        pixel("fw_f1", 10'd3);
        frame();
        pixel("fw_f2", 10'd5);
        cfg_write(2'd3, 16'hFFFF);
        frame();
        pixel("sel3_ignored", 10'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
